// File: rtl/game_tick_gen.sv
// Game-clock timing stage: qualifies PLL lock, divides the clock into a frame tick,
// and issues the level/soft-drop dependent gravity request with an ack handshake.
module game_tick_gen #(
    parameter int unsigned FRAME_DIV = 52083,
    parameter int unsigned LOCK_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic [3:0] level,
    input  logic       soft_drop,
    input  logic       pause,
    input  logic       fall_ack,
    output logic       ready,
    output logic       frame_tick,
    output logic       fall_req,
    output logic       overrun
);

    localparam int unsigned DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
    localparam int unsigned FRM_W  = 6;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RUN       = 2'd1,
        PAUSED    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [FRM_W-1:0]    frm_q, frm_d;
    logic                ready_q, ready_d;
    logic                tick_q, tick_d;
    logic                req_q, req_d;
    logic                ovr_q, ovr_d;

    logic [FRM_W-1:0]    interval_c;
    logic [FRM_W:0]      frm_inc_c;
    logic                wrap_c;
    logic                due_c;

    // Frames per gravity step; soft drop overrides the level table.
    always_comb begin
        interval_c = FRM_W'(4);
        if (soft_drop) begin
            interval_c = FRM_W'(2);
        end else begin
            case (level)
                4'd0:    interval_c = FRM_W'(48);
                4'd1:    interval_c = FRM_W'(43);
                4'd2:    interval_c = FRM_W'(38);
                4'd3:    interval_c = FRM_W'(33);
                4'd4:    interval_c = FRM_W'(28);
                4'd5:    interval_c = FRM_W'(23);
                4'd6:    interval_c = FRM_W'(18);
                4'd7:    interval_c = FRM_W'(13);
                4'd8:    interval_c = FRM_W'(8);
                4'd9:    interval_c = FRM_W'(6);
                4'd10,
                4'd11,
                4'd12:   interval_c = FRM_W'(5);
                default: interval_c = FRM_W'(4);
            endcase
        end
    end

    assign wrap_c    = (div_q == DIV_W'(FRAME_DIV - 1));
    assign frm_inc_c = {1'b0, frm_q} + (FRM_W + 1)'(1);

    // Next-state and counter logic; ack handling stays live while paused.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        div_d   = div_q;
        frm_d   = frm_q;
        tick_d  = 1'b0;
        req_d   = req_q;
        ovr_d   = ovr_q;
        due_c   = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                req_d = 1'b0;
                div_d = '0;
                frm_d = '0;
                if (sync2_q) begin
                    if (hold_q == HOLD_W'(LOCK_HOLD - 1)) begin
                        state_d = RUN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    hold_d = '0;
                end
            end
            RUN, PAUSED: begin
                if (!sync2_q) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                    div_d   = '0;
                    frm_d   = '0;
                    req_d   = 1'b0;
                end else begin
                    if (state_q == RUN) begin
                        if (pause) begin
                            state_d = PAUSED;
                            if (!wrap_c) begin
                                div_d = div_q + DIV_W'(1);
                            end
                        end else if (wrap_c) begin
                            div_d  = '0;
                            tick_d = 1'b1;
                            due_c  = (frm_inc_c >= {1'b0, interval_c});
                            frm_d  = due_c ? '0 : FRM_W'(frm_inc_c);
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end else if (!pause) begin
                        state_d = RUN;
                    end

                    if (due_c) begin
                        if (req_q && !fall_ack) begin
                            ovr_d = 1'b1;
                        end
                        req_d = 1'b1;
                    end else if (req_q && fall_ack) begin
                        req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                hold_d  = '0;
                div_d   = '0;
                frm_d   = '0;
                req_d   = 1'b0;
            end
        endcase

        ready_d = (state_d != WAIT_LOCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hold_q  <= '0;
            div_q   <= '0;
            frm_q   <= '0;
            ready_q <= 1'b0;
            tick_q  <= 1'b0;
            req_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
            hold_q  <= hold_d;
            div_q   <= div_d;
            frm_q   <= frm_d;
            ready_q <= ready_d;
            tick_q  <= tick_d;
            req_q   <= req_d;
            ovr_q   <= ovr_d;
        end
    end

    assign ready      = ready_q;
    assign frame_tick = tick_q;
    assign fall_req   = req_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen with a short frame (10 cycles) and lock hold of 4.
module tb_game_tick_gen;

    localparam int unsigned FD = 10;
    localparam int unsigned LH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic [3:0] level;
    logic       soft_drop;
    logic       pause;
    logic       fall_ack;
    logic       ready;
    logic       frame_tick;
    logic       fall_req;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    game_tick_gen #(.FRAME_DIV(FD), .LOCK_HOLD(LH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .level      (level),
        .soft_drop  (soft_drop),
        .pause      (pause),
        .fall_ack   (fall_ack),
        .ready      (ready),
        .frame_tick (frame_tick),
        .fall_req   (fall_req),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] lvl;
        logic       sd;
        int         frames;
        int         gap;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs gap edges expecting frame_tick only on the last; optional ack on edge ack_at.
    task automatic tick_after(input int gap, input int ack_at);
        for (int i = 1; i <= gap; i++) begin
            fall_ack = (i == ack_at);
            step();
            fall_ack = 1'b0;
            if (i == ack_at && i < gap) check("ack_clear", 32'(fall_req), 0);
            if (i < gap) check("tick_quiet", 32'(frame_tick), 0);
            else         check("tick_due", 32'(frame_tick), 1);
        end
    endtask

    initial begin
        bit ack_next;
        rst        = 1'b1;
        pll_locked = 1'b0;
        level      = 4'd0;
        soft_drop  = 1'b0;
        pause      = 1'b0;
        fall_ack   = 1'b0;

        tbl[0] = '{lvl: 4'd0,  sd: 1'b0, frames: 96, gap: 48};
        tbl[1] = '{lvl: 4'd9,  sd: 1'b0, frames: 12, gap: 6};
        tbl[2] = '{lvl: 4'd8,  sd: 1'b0, frames: 16, gap: 8};
        tbl[3] = '{lvl: 4'd11, sd: 1'b0, frames: 10, gap: 5};
        tbl[4] = '{lvl: 4'd14, sd: 1'b0, frames: 8,  gap: 4};
        tbl[5] = '{lvl: 4'd3,  sd: 1'b1, frames: 6,  gap: 2};

        // Reset state and lock qualification
        repeat (3) step();
        check("rst_ready", 32'(ready), 0);
        check("rst_tick", 32'(frame_tick), 0);
        check("rst_req", 32'(fall_req), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        step();
        check("unlocked_ready", 32'(ready), 0);
        pll_locked = 1'b1;
        for (int e = 1; e <= 2 + int'(LH); e++) begin
            step();
            check("lock_ready", 32'(ready), (e == 2 + int'(LH)) ? 1 : 0);
            if (e < 2 + int'(LH)) check("lock_req", 32'(fall_req), 0);
        end

        // Gravity intervals per level/soft-drop, ack one cycle after each rise
        ack_next = 1'b0;
        for (int r = 0; r < 6; r++) begin
            level     = tbl[r].lvl;
            soft_drop = tbl[r].sd;
            for (int f = 1; f <= tbl[r].frames; f++) begin
                tick_after(int'(FD), ack_next ? 1 : 0);
                ack_next = ((f % tbl[r].gap) == 0);
                check("drop_req", 32'(fall_req), ack_next ? 1 : 0);
            end
        end
        check("table_ovr", 32'(overrun), 0);

        // Level 0 -> 15 after frame 5 makes the drop due on the next frame
        level     = 4'd0;
        soft_drop = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            tick_after(int'(FD), (f == 1) ? 1 : 0);
            check("lvlsw_quiet", 32'(fall_req), 0);
        end
        level = 4'd15;
        tick_after(int'(FD), 0);
        check("lvlsw_due", 32'(fall_req), 1);

        // Soft drop: ack+due on one edge, then unacked overrun
        soft_drop = 1'b1;
        tick_after(int'(FD), 1);
        check("sd_f1_req", 32'(fall_req), 0);
        tick_after(int'(FD), 0);
        check("sd_f2_req", 32'(fall_req), 1);
        tick_after(int'(FD), 0);
        check("sd_f3_req", 32'(fall_req), 1);
        check("sd_f3_ovr", 32'(overrun), 0);
        tick_after(int'(FD), int'(FD));
        check("ackdue_req", 32'(fall_req), 1);
        check("ackdue_ovr", 32'(overrun), 0);
        tick_after(int'(FD), 0);
        tick_after(int'(FD), 0);
        check("ovr_req", 32'(fall_req), 1);
        check("ovr_set", 32'(overrun), 1);
        tick_after(int'(FD), 0);
        tick_after(int'(FD), int'(FD));
        check("ackdue2_req", 32'(fall_req), 1);
        check("ackdue2_ovr", 32'(overrun), 1);

        // Pause 25 cycles starting 3 cycles into a frame: next tick 25 cycles late
        for (int i = 1; i <= int'(FD) + 25; i++) begin
            pause = (i >= 4 && i <= 28);
            step();
            check("pause_tick", 32'(frame_tick), (i == int'(FD) + 25) ? 1 : 0);
            if (i == 15) check("pause_ready", 32'(ready), 1);
        end
        pause = 1'b0;
        check("pause_req", 32'(fall_req), 1);

        // Lock loss with request pending and overrun set
        pll_locked = 1'b0;
        step();
        check("loss_e1_ready", 32'(ready), 1);
        step();
        check("loss_e2_ready", 32'(ready), 1);
        step();
        check("loss_e3_ready", 32'(ready), 0);
        check("loss_e3_req", 32'(fall_req), 0);
        check("loss_e3_ovr", 32'(overrun), 1);

        // Re-lock restarts timing from frame 0
        pll_locked = 1'b1;
        for (int e = 1; e <= 2 + int'(LH); e++) begin
            step();
            check("relock_ready", 32'(ready), (e == 2 + int'(LH)) ? 1 : 0);
        end
        tick_after(int'(FD), 0);
        check("relock_f1_req", 32'(fall_req), 0);
        tick_after(int'(FD), 0);
        check("relock_f2_req", 32'(fall_req), 1);
        check("relock_ovr", 32'(overrun), 1);

        // Asynchronous reset clears everything between edges
        #2;
        rst = 1'b1;
        #1;
        check("async_ready", 32'(ready), 0);
        check("async_req", 32'(fall_req), 0);
        check("async_ovr", 32'(overrun), 0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_tick_gen.md
# game_tick_gen

Timing stage directly downstream of the game-clock PLL. It runs on the PLL output clock and qualifies the PLL lock indication through a synchronizer and a hold-off counter. It then divides the clock into a 60 Hz frame tick and produces the Tetris gravity request: a held request, acknowledged by the piece-control logic, whose period depends on level and soft-drop. All game logic downstream uses `ready`, `frame_tick` and `fall_req` from this block.

## Interface
- `FRAME_DIV`, 52083: clock cycles per frame (3.125 MHz / 60 Hz, truncated).
- `LOCK_HOLD`, 16: cycles synchronized lock must stay high before `ready` rises; minimum 1.
- `clk`  in  1  game clock, the PLL output clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pll_locked`  in  1  PLL lock; asynchronous to `clk`.
- `level`  in  4  current game level, 0..15.
- `soft_drop`  in  1  soft-drop button, already debounced.
- `pause`  in  1  freezes all game timing while high.
- `fall_ack`  in  1  consumer accepted the pending gravity step.
- `ready`  out  1  high in RUN and PAUSED.
- `frame_tick`  out  1  one-cycle pulse per frame.
- `fall_req`  out  1  gravity step pending; held until acknowledged.
- `overrun`  out  1  sticky flag: a gravity step fell due while one was still pending.

## Operation
- **Reset.** `rst` high asynchronously clears everything:
  - state becomes WAIT_LOCK;
  - both synchronizer flops, `hold_cnt`, `div_cnt` and `frm_cnt` become 0;
  - all outputs become 0.
- **Lock synchronizer.** Two flops on `pll_locked` produce `locked_s`.
- **WAIT_LOCK state.**
  - `hold_cnt` increments while `locked_s`=1 and clears when `locked_s`=0.
  - On an edge where `locked_s`=1 and `hold_cnt`==LOCK_HOLD-1, the state moves to RUN and `div_cnt` and `frm_cnt` become 0.
- **RUN state.**
  - `div_cnt` counts 0..FRAME_DIV-1 and wraps to 0.
  - On the wrap edge, the registered `frame_tick` is set for exactly one cycle and frame accounting is done.
- **Frame accounting** (evaluated on the wrap edge).
  - Interval: 2 if `soft_drop`=1, otherwise taken from the level table below.
  - Level table (frames per drop): L0 48, L1 43, L2 38, L3 33, L4 28, L5 23, L6 18, L7 13, L8 8, L9 6, L10–12 5, L13–15 4.
  - `level` and `soft_drop` are sampled at every wrap, not latched per drop.
  - If `frm_cnt`+1 >= interval, the drop is due and `frm_cnt` becomes 0; otherwise `frm_cnt` increments. The `>=` compare makes a level increase or a soft-drop press that shortens the interval take effect on the next frame.
  - `frm_cnt` is 6 bits.
- **fall_req handshake.**
  - A due drop sets `fall_req`.
  - `fall_ack`=1 while `fall_req`=1 clears `fall_req` on that edge.
  - Ack and a new due drop on the same edge: `fall_req` stays 1 and `overrun` is not set.
  - New due drop while `fall_req`=1 with no ack: `fall_req` stays 1 and `overrun` becomes 1.
  - `fall_ack` while `fall_req`=0 is ignored.
- **PAUSED state.**
  - `pause`=1 in RUN moves the state to PAUSED on the next edge. `pause` is also checked on the wrap edge itself: if `pause`=1 there, the tick is suppressed and `div_cnt` holds.
  - In PAUSED, `div_cnt` and `frm_cnt` are frozen, no `frame_tick` is generated, and `fall_req` and `fall_ack` handling stay active.
  - `pause`=0 returns to RUN on the next edge and counting resumes from the frozen values.
- **Lock loss.** `locked_s`=0 in RUN or PAUSED moves the state to WAIT_LOCK on the next edge:
  - `ready`, `frame_tick` and `fall_req` become 0;
  - `div_cnt`, `frm_cnt` and `hold_cnt` become 0;
  - `overrun` is retained and is cleared only by `rst`.
- `div_cnt` width is clog2(FRAME_DIV).

## Timing
- Every output is registered; there are no combinational paths from input to output.
- Lock qualification: `ready` rises on edge 2+LOCK_HOLD after the edge that first samples `pll_locked` high, provided `pll_locked` stays high.
- Lock loss: `ready` falls on edge 3 after `pll_locked` is first sampled low.
- First `frame_tick` is FRAME_DIV cycles after `ready` rises; after that it repeats every FRAME_DIV cycles while in RUN.
- `fall_req` rises in the same cycle as the `frame_tick` that made the drop due.
- `fall_req` falls in the cycle after `fall_ack` is sampled high.
- Each PAUSED cycle delays all later ticks by exactly one cycle.

## Test plan
Unless stated otherwise, FRAME_DIV=10, LOCK_HOLD=4, and `pll_locked` is already high after reset.

- Reset and lock: release `rst`, then raise `pll_locked` → `ready`=0 until edge 6, `ready`=1 at edge 6; all outputs 0 before that.
- Level 0 gravity: level=0, ack each request one cycle after it rises → `frame_tick` every 10 cycles; `fall_req` first rises with frame 48 (480 cycles after `ready`) and again with frame 96; `overrun`=0.
- Soft drop and level change: level=9 → drop every 6 frames; set `soft_drop` → drop every 2 frames; at frame 5 of a level-0 interval switch level 0→15 → drop due at the next frame.
- Overrun: soft_drop=1, never ack → `fall_req` rises at frame 2 and stays 1; `overrun`=1 at frame 4. Ack and a due drop on the same edge → `fall_req` stays 1, `overrun` unchanged.
- Pause: `pause`=1 for 25 cycles, starting 3 cycles into a frame → no `frame_tick` while paused; the next tick arrives exactly 25 cycles later than it would have without the pause.
- Lock loss: drop `pll_locked` while `fall_req`=1 and `overrun`=1 → `ready` and `fall_req` are 0 at edge 3, `overrun` stays 1; re-lock → timing restarts from frame 0.
